byte_store_serializer: RTL and testbench

BYTE_STORE_SERIALIZER -- requirements
Module: byte_store_serializer

---
 rtl/byte_store_serializer.sv | 181 ++++++++++++++++++
 tb/tb_byte_store_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_store_serializer.sv
// Serializes a byte/halfword/word store into little-endian byte writes on an
// 8-bit memory port, rejecting misaligned or illegal-size requests.
module byte_store_serializer #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_data,
  input  logic              i_mem_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_trunc_ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        last_q, last_d;
  logic [31:0]       data_q, data_d;
  logic              ovf_q, ovf_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              trunc_ovf_q, trunc_ovf_d;

  logic              req_bad;
  logic              req_ovf;
  logic [1:0]        req_last;

  // Request decode straight from the inputs; only used in the IDLE accept cycle.
  always_comb begin
    req_bad  = 1'b0;
    req_ovf  = 1'b0;
    req_last = 2'd0;
    case (i_size)
      SZ_BYTE: begin
        req_ovf  = (i_data[31:8] != {24{i_data[7]}});
        req_last = 2'd0;
      end
      SZ_HALF: begin
        req_bad  = i_addr[0];
        req_ovf  = (i_data[31:16] != {16{i_data[15]}});
        req_last = 2'd1;
      end
      SZ_WORD: begin
        req_bad  = (i_addr[1:0] != 2'b00);
        req_last = 2'd3;
      end
      default: req_bad = 1'b1;
    endcase
  end

  // NOTE: every _d gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    data_d      = data_q;
    ovf_d       = ovf_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    trunc_ovf_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_we_d = 1'b0;
        busy_d   = 1'b0;
        if (i_start) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            state_d     = S_WRITE;
            idx_d       = 2'd0;
            last_d      = req_last;
            data_d      = i_data;
            ovf_d       = req_ovf;
            mem_we_d    = 1'b1;
            mem_addr_d  = i_addr;
            mem_wdata_d = i_data[7:0];
            busy_d      = 1'b1;
          end
        end
      end

      S_WRITE: begin
        // Port outputs stay frozen until the memory takes the byte.
        if (i_mem_ready) begin
          if (idx_q == last_q) begin
            state_d     = S_DONE;
            mem_we_d    = 1'b0;
            done_d      = 1'b1;
            trunc_ovf_d = ovf_q;
          end else begin
            idx_d       = idx_q + 2'd1;
            data_d      = data_q >> 8;
            mem_addr_d  = mem_addr_q + ADDR_ONE;
            mem_wdata_d = data_q[15:8];
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d  = S_IDLE;
        mem_we_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      data_q      <= 32'd0;
      ovf_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      trunc_ovf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      trunc_ovf_q <= trunc_ovf_d;
    end
  end

  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_trunc_ovf = trunc_ovf_q;

endmodule

// File: tb/tb_byte_store_serializer.sv
// Directed bench for byte_store_serializer: a table of single stores applied
// back to back, plus stall, reset-abort and held-start sequences.
module tb_byte_store_serializer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [1:0]  i_size;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_mem_ready;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_trunc_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  byte_store_serializer #(.ADDR_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_size      (i_size),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .i_mem_ready (i_mem_ready),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_trunc_ovf (o_trunc_ovf)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] bytes_le;  // expected bytes, first write in [7:0]
    int          nbytes;    // 0 means rejected with o_err
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " we"}, {31'd0, o_mem_we}, 32'd0);
    check({tag, " done"}, {31'd0, o_done}, 32'd0);
    check({tag, " busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, " ovf"}, {31'd0, o_trunc_ovf}, 32'd0);
  endtask

  // Issues one request with ready high and checks the full response timeline.
  task automatic run_vec(input vec_t v, input int id);
    string tag;
    tag = $sformatf("v%0d", id);
    i_start = 1'b1;
    i_size  = v.size;
    i_addr  = v.addr;
    i_data  = v.data;
    step();
    i_start = 1'b0;
    if (v.nbytes == 0) begin
      check({tag, " err"}, {31'd0, o_err}, 32'd1);
      check({tag, " err we"}, {31'd0, o_mem_we}, 32'd0);
      check({tag, " err busy"}, {31'd0, o_busy}, 32'd0);
      step();
      check({tag, " err clr"}, {31'd0, o_err}, 32'd0);
      check({tag, " err we2"}, {31'd0, o_mem_we}, 32'd0);
    end else begin
      for (int i = 0; i < v.nbytes; i++) begin
        logic [31:0] exp_bytes;
        exp_bytes = v.bytes_le >> (8 * i);
        check($sformatf("%s we%0d", tag, i), {31'd0, o_mem_we}, 32'd1);
        check($sformatf("%s addr%0d", tag, i), o_mem_addr, v.addr + i);
        check($sformatf("%s wdata%0d", tag, i), {24'd0, o_mem_wdata}, {24'd0, exp_bytes[7:0]});
        check($sformatf("%s done%0d", tag, i), {31'd0, o_done}, 32'd0);
        step();
      end
      check({tag, " done"}, {31'd0, o_done}, 32'd1);
      check({tag, " ovf"}, {31'd0, o_trunc_ovf}, {31'd0, v.ovf});
      check({tag, " done we"}, {31'd0, o_mem_we}, 32'd0);
      check({tag, " done busy"}, {31'd0, o_busy}, 32'd1);
      step();
      check_idle_outputs({tag, " post"});
    end
  endtask

  initial begin
    //          size   addr          data          bytes_le      n  ovf
    vecs[0]  = '{2'b10, 32'h0000_0100, 32'h1122_3344, 32'h1122_3344, 4, 1'b0};
    vecs[1]  = '{2'b00, 32'h0000_0300, 32'hFFFF_FF80, 32'h0000_0080, 1, 1'b0};
    vecs[2]  = '{2'b00, 32'h0000_0301, 32'h0000_0080, 32'h0000_0080, 1, 1'b1};
    vecs[3]  = '{2'b01, 32'h0000_0201, 32'h0000_1234, 32'h0000_0000, 0, 1'b0};
    vecs[4]  = '{2'b11, 32'h0000_0000, 32'h0000_0055, 32'h0000_0000, 0, 1'b0};
    vecs[5]  = '{2'b10, 32'h0000_0102, 32'h1122_3344, 32'h0000_0000, 0, 1'b0};
    vecs[6]  = '{2'b01, 32'h0000_0202, 32'hFFFF_8001, 32'h0000_8001, 2, 1'b0};
    vecs[7]  = '{2'b01, 32'h0000_0204, 32'h0001_8001, 32'h0000_8001, 2, 1'b1};
    vecs[8]  = '{2'b10, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4, 1'b0};
    vecs[9]  = '{2'b00, 32'h0000_0007, 32'h0000_007F, 32'h0000_007F, 1, 1'b0};
    vecs[10] = '{2'b10, 32'h0000_0010, 32'h8000_0000, 32'h8000_0000, 4, 1'b0};

    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_size      = 2'b00;
    i_addr      = 32'd0;
    i_data      = 32'd0;
    i_mem_ready = 1'b1;
    #2;
    check_idle_outputs("reset");
    check("reset err", {31'd0, o_err}, 32'd0);
    check("reset addr", o_mem_addr, 32'd0);
    check("reset wdata", {24'd0, o_mem_wdata}, 32'd0);
    #10 i_rst_n = 1'b1;
    step();

    // Back-to-back table: each request issued in the first idle cycle.
    for (int k = 0; k < 11; k++) run_vec(vecs[k], k);

    // Halfword with memory stalled three cycles on byte 0.
    i_mem_ready = 1'b0;
    i_start = 1'b1; i_size = 2'b01; i_addr = 32'h0000_0400; i_data = 32'h0000_7FFF;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall we c%0d", c), {31'd0, o_mem_we}, 32'd1);
      check($sformatf("stall addr c%0d", c), o_mem_addr, 32'h0000_0400);
      check($sformatf("stall wdata c%0d", c), {24'd0, o_mem_wdata}, 32'h0000_00FF);
      if (c == 2) i_mem_ready = 1'b1;
      step();
    end
    check("stall we b1", {31'd0, o_mem_we}, 32'd1);
    check("stall addr b1", o_mem_addr, 32'h0000_0401);
    check("stall wdata b1", {24'd0, o_mem_wdata}, 32'h0000_007F);
    step();
    check("stall done", {31'd0, o_done}, 32'd1);
    check("stall ovf", {31'd0, o_trunc_ovf}, 32'd0);
    step();

    // Reset asserted once two bytes of a word store have been written.
    i_start = 1'b1; i_size = 2'b10; i_addr = 32'h0000_0500; i_data = 32'hCAFE_F00D;
    step();
    i_start = 1'b0;
    step();
    step();
    check("rst pre wdata", {24'd0, o_mem_wdata}, 32'h0000_00FE);
    i_rst_n = 1'b0;
    #1;
    check_idle_outputs("rst async");
    check("rst async addr", o_mem_addr, 32'd0);
    check("rst async wdata", {24'd0, o_mem_wdata}, 32'd0);
    step();
    #3 i_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("rst post we c%0d", c), {31'd0, o_mem_we}, 32'd0);
      check($sformatf("rst post done c%0d", c), {31'd0, o_done}, 32'd0);
    end
    run_vec(vecs[0], 100);

    // i_start held high: one word store, the next only after DONE.
    i_start = 1'b1; i_size = 2'b10; i_addr = 32'h0000_0600; i_data = 32'hA1B2_C3D4;
    for (int c = 1; c <= 7; c++) begin
      logic exp_we, exp_done, exp_busy;
      step();
      exp_we   = (c <= 4) || (c == 7);
      exp_done = (c == 5);
      exp_busy = (c != 6);
      check($sformatf("hold we c%0d", c), {31'd0, o_mem_we}, {31'd0, exp_we});
      check($sformatf("hold done c%0d", c), {31'd0, o_done}, {31'd0, exp_done});
      check($sformatf("hold busy c%0d", c), {31'd0, o_busy}, {31'd0, exp_busy});
    end
    check("hold restart wdata", {24'd0, o_mem_wdata}, 32'h0000_00D4);
    check("hold restart addr", o_mem_addr, 32'h0000_0600);
    i_start = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("hold second done", {31'd0, o_done}, 32'd1);
    step();
    check_idle_outputs("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
